mult_share_scheduler: RTL
=========================

# mult_share_scheduler

Round-robin scheduler that time-shares one sequential multiplier (the `Multiplier_StateBranch`-style engine) between two requesters, A and B. It accepts a request, latches the operands and issues `start` to the engine. It captures the product on `productDone` and returns it to the owning requester. With constant-time release enabled, each result comes back a fixed number of cycles after acceptance, regardless of operand values. Data-dependent engine latency is therefore never visible at the requester ports. The block sits between the requester logic and a single multiplier instance.

## Interface
- `WIDTH`, 1024, operand width; product is 2*WIDTH
- `LATENCY`, WIDTH+4, WAIT-state cycle count in constant-time mode (must be ≥ worst-case engine latency)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `reqA`, `reqB`  in  1  level request, held until matching ack
- `multiplierA`, `multiplicandA`, `multiplierB`, `multiplicandB`  in  WIDTH  operands, sampled in ack cycle
- `ackA`, `ackB`  out  1  one-cycle pulse: request accepted, operands latched
- `doneA`, `doneB`  out  1  one-cycle pulse: `product` valid for that requester
- `product`  out  2*WIDTH  result, valid only while a done is high, else 0
- `overrun`  out  1  pulses with done when the engine missed the LATENCY window
- `busy`  out  1  high in any state except IDLE
- `multStart`  out  1  one-cycle start to engine
- `multMultiplier`, `multMultiplicand`  out  WIDTH  latched operands, stable from ISSUE through RELEASE
- `multProduct`  in  2*WIDTH  engine result
- `multProductDone`  in  1  engine completion, sampled only in WAIT

## Operation
- States: IDLE → ISSUE → WAIT → RELEASE → IDLE.
- **IDLE:** on a rising edge with `reqA` or `reqB` high:
  - Select the owner and move to ISSUE.
  - If both are high, grant the requester not served last. The round-robin pointer resets to "B last", so A wins the first tie.
- **ISSUE (1 cycle):**
  - `ackOwner=1` and `multStart=1`.
  - Operands were latched on the entering edge.
  - Counter cleared to 0 and `captured` flag cleared.
- **WAIT:**
  - Counter increments each cycle.
  - First `multProductDone=1` latches `multProduct` into the result register and sets `captured`. Later pulses are ignored.
- **WAIT exit:**
  - With constant-time enabled: exit when counter == LATENCY-1.
  - With constant-time disabled: exit on the cycle after capture.
- **RELEASE (1 cycle):**
  - `doneOwner=1`, `product` = result register, `overrun` = ~`captured`.
  - On overrun, `product` = 0.
  - The round-robin pointer updates to the owner.
- A request dropped after its ack has no effect. A request dropped before its ack is simply not served.
- `multProductDone` outside WAIT is ignored.
- All outputs are registered or decoded from the state register. No combinational path from req to ack.

## Timing
- Reset values: state IDLE, all pulses 0, `product`=0, `busy`=0, operand latches 0, pointer "B last". `rst` mid-operation aborts immediately. No done is issued for the aborted request, and the engine is expected to be reset by the same `rst`.
- Constant-time cycle numbering: ack and `multStart` at cycle 0, WAIT at cycles 1..LATENCY, done at cycle LATENCY+1, IDLE at LATENCY+2.
- The earliest next ack is at LATENCY+3, so back-to-back throughput is one result per LATENCY+3 cycles.
- Non-constant-time: if `multProductDone` is seen at cycle k (k≥1), done occurs at cycle k+1. There is no timeout, so a missing productDone stalls the block until reset.
- The ack→done distance in constant-time mode is identical for every operand pair and for both requesters.

## Configuration
- `MULT_SCHED_CONST_TIME_EN` defined: fixed LATENCY window, the `overrun` check, and done at cycle LATENCY+1.
- `MULT_SCHED_CONST_TIME_EN` undefined: release on capture+1, and `overrun` is tied to 0.
- The LATENCY parameter is unused when the macro is undefined.

## Test plan
All scenarios use WIDTH=8 and LATENCY=12, with a behavioural engine model whose productDone delay is programmable.
- **Single request, macro on:** reqA with 13×11, engine delay 5 → ackA at cycle 0, doneA at cycle 13, `product`=143, `overrun`=0, `busy` low at cycle 14.
- **Constant-time check, macro on:** A 255×255 with delay 9, then B 1×0 with delay 2 → both dones exactly 13 cycles after their acks, products 65025 and 0.
- **Simultaneous requests:** reqA and reqB both from cycle 0 → ackA first, ackB 15 cycles later. A second tie after that grants A again, since B was served last.
- **Overrun, macro on:** engine delay 14 → doneA at cycle 13 with `overrun`=1 and `product`=0. The late productDone is ignored and the next request is served normally.
- **Reset mid-WAIT:** `rst` pulsed at cycle 6 → all outputs 0 immediately, no doneA. The next reqA is acked one cycle after its first sampled edge.
- **Macro off:** engine delay 3 for 7×6 → doneA at cycle 4 with `product`=42, and `overrun` never asserts.

Source files
------------

// File: rtl/mult_share_scheduler.sv
// mult_share_scheduler: round-robin time-sharing of one sequential multiplier
// engine between requesters A and B.
// Optional feature macro: MULT_SCHED_CONST_TIME_EN. When it is defined, results
// are released a fixed LATENCY window after acceptance, and a late engine raises
// overrun. When it is undefined, the result is released the cycle after capture.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no job; arbitrate reqA/reqB, latch winner's operands
// S_ISSUE   | ack + multStart pulse to the engine, clear counter/captured
// S_WAIT    | count cycles, capture first multProductDone
// S_RELEASE | done pulse with product (or overrun), update round-robin ptr
module mult_share_scheduler #(
  parameter int WIDTH   = 1024,
  parameter int LATENCY = WIDTH + 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reqA,
  input  logic                 reqB,
  input  logic [WIDTH-1:0]     multiplierA,
  input  logic [WIDTH-1:0]     multiplicandA,
  input  logic [WIDTH-1:0]     multiplierB,
  input  logic [WIDTH-1:0]     multiplicandB,
  output logic                 ackA,
  output logic                 ackB,
  output logic                 doneA,
  output logic                 doneB,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overrun,
  output logic                 busy,
  output logic                 multStart,
  output logic [WIDTH-1:0]     multMultiplier,
  output logic [WIDTH-1:0]     multMultiplicand,
  input  logic [2*WIDTH-1:0]   multProduct,
  input  logic                 multProductDone
);

  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

  state_t             state;
  logic               ownerB;
  logic               lastB;
  logic               captured;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] result;
  logic               grantB;
  logic               hit;
  logic               waitExit;

  // B wins when it is the only requester, or on a tie when A was served last.
  assign grantB = reqB & (~reqA | ~lastB);

  // A result is available if captured earlier or arriving this very cycle.
  assign hit = captured | multProductDone;

`ifdef MULT_SCHED_CONST_TIME_EN
  assign waitExit = (count == CW'(LATENCY - 1));
`else
  assign waitExit = hit;
`endif

  assign busy = (state != S_IDLE);

  // Scheduler FSM with registered pulse outputs and operand/result latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      ownerB           <= 1'b0;
      lastB            <= 1'b1;
      captured         <= 1'b0;
      count            <= '0;
      result           <= '0;
      ackA             <= 1'b0;
      ackB             <= 1'b0;
      doneA            <= 1'b0;
      doneB            <= 1'b0;
      product          <= '0;
      overrun          <= 1'b0;
      multStart        <= 1'b0;
      multMultiplier   <= '0;
      multMultiplicand <= '0;
    end else begin
      ackA      <= 1'b0;
      ackB      <= 1'b0;
      doneA     <= 1'b0;
      doneB     <= 1'b0;
      product   <= '0;
      overrun   <= 1'b0;
      multStart <= 1'b0;
      case (state)
        S_IDLE: begin
          if (reqA | reqB) begin
            ownerB           <= grantB;
            multMultiplier   <= grantB ? multiplierB : multiplierA;
            multMultiplicand <= grantB ? multiplicandB : multiplicandA;
            ackA             <= ~grantB;
            ackB             <= grantB;
            multStart        <= 1'b1;
            state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          count    <= '0;
          captured <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (count != '1) count <= count + 1'b1;
          if (multProductDone && !captured) begin
            captured <= 1'b1;
            result   <= multProduct;
          end
          if (waitExit) begin
            doneA   <= ~ownerB;
            doneB   <= ownerB;
            product <= captured ? result : (multProductDone ? multProduct : '0);
`ifdef MULT_SCHED_CONST_TIME_EN
            overrun <= ~hit;
`endif
            lastB   <= ownerB;
            state   <= S_RELEASE;
          end
        end
        S_RELEASE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule
